// File: rtl/seq_nr_divider.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock,
// start/done handshake, divide-by-zero detection and final remainder correction.
module seq_nr_divider #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CORR,
    DONE
  } state_t;

  state_t          state_q;
  logic   [M:0]    p_q;
  logic   [N-1:0]  q_q;
  logic   [M-1:0]  d_q;
  logic   [CW-1:0] cnt_q;
  logic            dz_q;
  logic            busy_q;
  logic            done_q;
  logic   [N-1:0]  quo_q;
  logic   [M-1:0]  rem_q;
  logic            dbz_q;

  logic   [M:0]    p_shift;
  logic   [M:0]    p_iter_d;
  logic   [N-1:0]  q_iter_d;
  logic   [M:0]    p_corr_d;

  // P wraps modulo 2^(M+1); the sign-driven add/subtract keeps the result in [-D, D).
  always_comb begin
    p_shift  = {p_q[M-1:0], q_q[N-1]};
    p_iter_d = p_q[M] ? (p_shift + {1'b0, d_q}) : (p_shift - {1'b0, d_q});
    q_iter_d = {q_q[N-2:0], ~p_iter_d[M]};
    p_corr_d = p_q[M] ? (p_q + {1'b0, d_q}) : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            p_q     <= '0;
            cnt_q   <= CW'(N);
            dz_q    <= (divisor == '0);
            busy_q  <= 1'b1;
            state_q <= (divisor == '0) ? DONE : ITER;
          end
        end
        ITER: begin
          p_q   <= p_iter_d;
          q_q   <= q_iter_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= CORR;
        end
        CORR: begin
          p_q     <= p_corr_d;
          state_q <= DONE;
        end
        DONE: begin
          // Results are published together with done; Q still holds the dividend on divide-by-zero.
          quo_q   <= dz_q ? '1 : q_q;
          rem_q   <= dz_q ? q_q[M-1:0] : p_q[M-1:0];
          dbz_q   <= dz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_nr_divider.sv
// Scoreboard bench for seq_nr_divider: an 8/4 instance with directed vectors
// and a 4/2 instance swept over all dividends and non-zero divisors.
module tb_seq_nr_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  logic       s_start;
  logic [3:0] s_dividend;
  logic [1:0] s_divisor;
  logic       s_busy, s_done, s_div_by_zero;
  logic [3:0] s_quotient;
  logic [1:0] s_remainder;

  seq_nr_divider #(.N(8), .M(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  seq_nr_divider #(.N(4), .M(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .dividend(s_dividend), .divisor(s_divisor),
    .busy(s_busy), .done(s_done), .quotient(s_quotient), .remainder(s_remainder),
    .div_by_zero(s_div_by_zero)
  );

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        dz;
    int unsigned lat;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        sexp_q[$];
  int unsigned acc_q[$];
  int unsigned sacc_q[$];

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned ndone = 0;
  int unsigned sndone = 0;
  int unsigned last_done_cyc = 0;
  int unsigned last_acc_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor first, then acceptance tracking, so a same-edge accept never overtakes a pop.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned a;
    if (done) begin
      ndone++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check({e.name, "_latency"}, cyc - a, e.lat);
        check({e.name, "_quotient"}, quotient, e.q);
        check({e.name, "_remainder"}, remainder, e.r);
        check({e.name, "_div_by_zero"}, div_by_zero, e.dz);
        check({e.name, "_busy_with_done"}, busy, 0);
      end
    end
    if (rst_n && start && !busy) begin
      acc_q.push_back(cyc + 1);
      last_acc_cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    exp_t        e;
    int unsigned a;
    if (s_done) begin
      sndone++;
      if (sexp_q.size() == 0 || sacc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL small_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sexp_q.pop_front();
        a = sacc_q.pop_front();
        check({e.name, "_latency"}, cyc - a, e.lat);
        check({e.name, "_quotient"}, s_quotient, e.q);
        check({e.name, "_remainder"}, s_remainder, e.r);
        check({e.name, "_div_by_zero"}, s_div_by_zero, e.dz);
      end
    end
    if (rst_n && s_start && !s_busy) sacc_q.push_back(cyc + 1);
  end

  function automatic exp_t mk(input logic [7:0] q, input logic [3:0] r, input logic dz,
                              input int unsigned lat, input string name);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.name = name;
    return e;
  endfunction

  task automatic wait_done(input int unsigned target, input string name);
    int unsigned k = 0;
    while (ndone < target && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (ndone < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d dones, expected %0d", name, ndone, target);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                        input logic [3:0] r, input logic dz, input int unsigned lat,
                        input string name);
    int unsigned target;
    target = ndone + 1;
    @(posedge clk);
    #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(mk(q, r, dz, lat, name));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(target, name);
  endtask

  task automatic run_small(input logic [3:0] a, input logic [1:0] b);
    int unsigned target;
    int unsigned k;
    target = sndone + 1;
    k = 0;
    @(posedge clk);
    #1;
    s_dividend = a;
    s_divisor  = b;
    s_start    = 1'b1;
    sexp_q.push_back(mk(8'(a / b), 4'(a % b), 1'b0, 6, "small"));
    @(posedge clk);
    #1;
    s_start = 1'b0;
    while (sndone < target && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sndone < target) begin
      tests++;
      fails++;
      $display("FAIL small_timeout: got %0d dones for %0d/%0d, expected %0d", sndone, a, b, target);
    end
  endtask

  initial begin
    int unsigned d1;
    rst_n      = 1'b0;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    s_start    = 1'b0;
    s_dividend = '0;
    s_divisor  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_div_by_zero", div_by_zero, 0);

    // start already high when reset releases: accepted at the first rising edge
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    exp_q.push_back(mk(8'd14, 4'd2, 1'b0, 10, "100_div_7"));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1, "100_div_7");

    run_op(8'd255, 4'd15, 8'd17, 4'd0,  1'b0, 10, "255_div_15");
    run_op(8'd13,  4'd14, 8'd0,  4'd13, 1'b0, 10, "13_div_14");
    run_op(8'd200, 4'd0,  8'hFF, 4'd8,  1'b1, 1,  "200_div_0");
    run_op(8'd0,   4'd5,  8'd0,  4'd0,  1'b0, 10, "0_div_5");

    // start held high; inputs change mid-operation
    @(posedge clk);
    #1;
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    exp_q.push_back(mk(8'd14, 4'd2, 1'b0, 10, "held_first"));
    exp_q.push_back(mk(8'd16, 4'd2, 1'b0, 10, "held_second"));
    repeat (3) @(posedge clk);
    #1;
    dividend = 8'd50;
    divisor  = 4'd3;
    wait_done(ndone + 1, "held_first");
    d1 = last_done_cyc;
    check("held_reaccept_cycle", last_acc_cyc, d1 + 1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(ndone + 1, "held_second");

    // asynchronous reset during iteration 4 of 100/7
    @(posedge clk);
    #1;
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    exp_q.push_back(mk(8'd14, 4'd2, 1'b0, 10, "aborted"));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_quotient", quotient, 0);
    check("midreset_remainder", remainder, 0);
    check("midreset_div_by_zero", div_by_zero, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    run_op(8'd9, 4'd3, 8'd3, 4'd0, 1'b0, 10, "9_div_3");

    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 1; b < 4; b++) begin
        run_small(4'(a), 2'(b));
      end
    end

    repeat (12) @(posedge clk);
    #1;
    check("pending_expected", exp_q.size() + sexp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_nr_divider.md
# seq_nr_divider

Sequential, parametrised unsigned non-restoring divider: successor to the fixed 4-bit/2-bit combinational array divider, reusing the same CAS-style add/subtract recurrence but producing one quotient bit per clock. It supports arbitrary dividend/divisor widths, a start/done handshake, divide-by-zero detection and a final remainder-correction step. It is the shared arithmetic unit behind the datapath's integer divide operations.

## Interface

- N, default 8: dividend and quotient width (N ≥ 2).
- M, default 4: divisor and remainder width (1 ≤ M ≤ N).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy = 0.
- dividend  in  N  unsigned dividend; captured at the accepting edge.
- divisor  in  M  unsigned divisor; captured at the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- quotient  out  N  unsigned quotient.
- remainder  out  M  unsigned remainder, always < divisor when divisor ≠ 0.
- div_by_zero  out  1  set when the completed operation had divisor = 0.

## Operation

- States: IDLE, ITER, CORR, DONE.
- IDLE: start = 1 captures dividend into the Q shift register and divisor into D. The partial remainder P (M+1 bits, two's complement) is cleared to 0 and the iteration counter is set to N.
  - If the divisor is 0, go to DONE.
  - Otherwise go to ITER.
- ITER, once per edge:
  - Shift {P,Q} left by 1.
  - If the old P is ≥ 0, P = P − {0,D}; otherwise P = P + {0,D}. This is the same add/subtract control as the CAS array, with P driven by the sign.
  - The new Q LSB is the inverse of the new P sign bit.
  - Decrement the counter. When it reaches 0, go to CORR.
- CORR: if P < 0, P = P + {0,D}. quotient ← Q, remainder ← P[M-1:0], div_by_zero ← 0. Go to DONE.
- DONE for a divide-by-zero request: quotient ← all ones, remainder ← dividend[M-1:0], div_by_zero ← 1.
- DONE state behaviour: done = 1 for one cycle, then return to IDLE.
- quotient, remainder and div_by_zero hold their values until the next completion. They are not cleared when the next start is accepted.
- A start while busy = 1 is ignored. It is not queued.
- start = 1 during the DONE cycle is ignored. It is accepted in the next (IDLE) cycle.
- Arithmetic width rule: P holds M+1 bits, so every intermediate value fits for any dividend < 2^N.

## Timing

- Edge 0 accepts start. busy = 1 from edge 0.
- Edges 1..N are the iterations. Edge N+1 is CORR. done = 1 after edge N+2 (DONE), and busy = 0 after that same edge.
- Total latency from accepting edge to done high is N+2 edges (10 for N = 8). With divisor = 0 it is 1 edge.
- busy and done are never both 1.
- Throughput: one result every N+3 cycles when start is held high.
- Reset (rst_n = 0, any time, including mid-operation): takes effect immediately. State = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, internal registers = 0. The aborted operation produces no done.
- After rst_n deasserts, a start is accepted at the first rising edge.

## Test plan

- N=8, M=4: dividend 100, divisor 7 → done 10 edges after acceptance, quotient 14, remainder 2, div_by_zero 0.
- 255 / 15 → quotient 17, remainder 0. Then 13 / 14 → quotient 0, remainder 13. This exercises the CORR path because the final P is negative.
- 200 / 0 → done 1 edge after acceptance, quotient 0xFF, remainder 8, div_by_zero 1. A following 0 / 5 → quotient 0, remainder 0, div_by_zero 0.
- Hold start = 1 continuously with inputs changed mid-operation to 50 / 3:
  - The first result (100 / 7 → 14 r2) is unaffected.
  - The second operation is accepted exactly one cycle after done.
  - That second operation yields 16 r2.
- Pulse rst_n low at iteration 4 of 100 / 7:
  - All outputs are 0 immediately and no done appears.
  - A new 9 / 3 after reset → quotient 3, remainder 0.
- Exhaustive check for N=4, M=2, all dividends 0..15 and divisors 1..3: quotient and remainder match integer / and %, each with exactly one done pulse.
